// File: rtl/ac_eco_controller.sv
`default_nettype none
// ============================================================================
//  Module   : ac_eco_controller
//  Purpose  : Economy controller that shuts the AC compressor off while any
//             window or door stays open, restarts it after everything has
//             been closed for a while, and raises an alarm if an opening is
//             left open too long.
//  Revision : 1.0 - initial release
// ============================================================================
module ac_eco_controller #(
   parameter int HOME_WINDOW_COUNT   = 8,
   parameter int HOME_DOOR_COUNT     = 4,
   parameter int OPEN_DELAY_TICKS    = 30,
   parameter int RESTART_DELAY_TICKS = 60,
   parameter int ALARM_TICKS         = 600
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         tick_i,
   input  logic                         eco_mode_valid_i,
   input  logic                         ac_request_i,
   input  logic [HOME_WINDOW_COUNT-1:0] WINDOW_STATUS_i,
   input  logic [HOME_DOOR_COUNT-1:0]   DOOR_STATUS_i,
   output logic                         ac_enable_o,
   output logic [2:0]                   state_o,
   output logic                         open_alarm_o,
   output logic [7:0]                   eco_off_count_o
);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_RUN      = 3'd1;
   localparam logic [2:0] ST_WAIT_OFF = 3'd2;
   localparam logic [2:0] ST_ECO_OFF  = 3'd3;
   localparam logic [2:0] ST_RESTART  = 3'd4;

   // The tick that brings the count to the delay is the one seen while the
   // counter still holds delay-1.
   localparam logic [15:0] OPEN_LAST    = 16'(OPEN_DELAY_TICKS - 1);
   localparam logic [15:0] RESTART_LAST = 16'(RESTART_DELAY_TICKS - 1);
   localparam logic [15:0] ALARM_MAX    = 16'(ALARM_TICKS);

   logic        eco_mode;
   logic        ac_request;
   logic        open_any;
   logic        open_now;
   logic [2:0]  state;
   logic [2:0]  state_next;
   logic [15:0] tick_cnt;
   logic [15:0] alarm_cnt;
   logic [7:0]  eco_off_cnt;
   logic        state_change;
   logic        eco_off_entry;
   logic        eco_and_open;

   assign open_now      = |{WINDOW_STATUS_i, DOOR_STATUS_i};
   assign eco_and_open  = eco_mode & open_any;
   assign state_change  = (state_next != state);
   assign eco_off_entry = (state_next == ST_ECO_OFF) && (state != ST_ECO_OFF);

   // Single-stage input registers; the FSM only ever looks at these copies.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         eco_mode   <= 1'b0;
         ac_request <= 1'b0;
         open_any   <= 1'b0;
      end else begin
         eco_mode   <= eco_mode_valid_i;
         ac_request <= ac_request_i;
         open_any   <= open_now;
      end
   end

   // Next-state decode; a dropped request overrides every other transition.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (ac_request) state_next = eco_and_open ? ST_ECO_OFF : ST_RUN;
         end
         ST_RUN: begin
            if (!ac_request)       state_next = ST_IDLE;
            else if (eco_and_open) state_next = ST_WAIT_OFF;
         end
         ST_WAIT_OFF: begin
            if (!ac_request)                         state_next = ST_IDLE;
            else if (!eco_and_open)                  state_next = ST_RUN;
            else if (tick_i && tick_cnt == OPEN_LAST) state_next = ST_ECO_OFF;
         end
         ST_ECO_OFF: begin
            if (!ac_request)        state_next = ST_IDLE;
            else if (!eco_and_open) state_next = ST_RESTART;
         end
         ST_RESTART: begin
            if (!ac_request)                             state_next = ST_IDLE;
            else if (eco_and_open)                       state_next = ST_ECO_OFF;
            else if (tick_i && tick_cnt == RESTART_LAST) state_next = ST_RUN;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= ST_IDLE;
      else         state <= state_next;
   end

   // Delay counter: cleared on any transition, so a tick coinciding with the
   // entry cycle is discarded; counts only in the two timed states.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tick_cnt <= 16'd0;
      end else if (state_change) begin
         tick_cnt <= 16'd0;
      end else if (tick_i && (state == ST_WAIT_OFF || state == ST_RESTART)) begin
         tick_cnt <= tick_cnt + 16'd1;
      end
   end

   // Alarm counter: restarts on ECO_OFF entry and saturates at the threshold.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         alarm_cnt <= 16'd0;
      end else if (eco_off_entry) begin
         alarm_cnt <= 16'd0;
      end else if (tick_i && state == ST_ECO_OFF && alarm_cnt != ALARM_MAX) begin
         alarm_cnt <= alarm_cnt + 16'd1;
      end
   end

   // Saturating count of ECO_OFF entries.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         eco_off_cnt <= 8'd0;
      end else if (eco_off_entry && eco_off_cnt != 8'hFF) begin
         eco_off_cnt <= eco_off_cnt + 8'd1;
      end
   end

   assign state_o         = state;
   assign ac_enable_o     = (state == ST_RUN) || (state == ST_WAIT_OFF);
   assign open_alarm_o    = (state == ST_ECO_OFF) && (alarm_cnt == ALARM_MAX);
   assign eco_off_count_o = eco_off_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ac_eco_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ac_eco_controller
//  Purpose  : Self-checking bench for ac_eco_controller (short delays).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ac_eco_controller;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       tick_i = 1'b0;
   logic       eco_mode_valid_i = 1'b0;
   logic       ac_request_i = 1'b0;
   logic [7:0] WINDOW_STATUS_i = 8'h00;
   logic [3:0] DOOR_STATUS_i = 4'h0;
   logic       ac_enable_o;
   logic [2:0] state_o;
   logic       open_alarm_o;
   logic [7:0] eco_off_count_o;

   int checks = 0;
   int errors = 0;

   // Expected and observed {state, ac_enable, alarm, count} per step.
   logic [12:0] exp_q[$];
   logic [12:0] obs_q[$];

   ac_eco_controller #(
      .HOME_WINDOW_COUNT  (8),
      .HOME_DOOR_COUNT    (4),
      .OPEN_DELAY_TICKS   (3),
      .RESTART_DELAY_TICKS(2),
      .ALARM_TICKS        (5)
   ) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .tick_i          (tick_i),
      .eco_mode_valid_i(eco_mode_valid_i),
      .ac_request_i    (ac_request_i),
      .WINDOW_STATUS_i (WINDOW_STATUS_i),
      .DOOR_STATUS_i   (DOOR_STATUS_i),
      .ac_enable_o     (ac_enable_o),
      .state_o         (state_o),
      .open_alarm_o    (open_alarm_o),
      .eco_off_count_o (eco_off_count_o)
   );

   always #5 clk_i = ~clk_i;

   // Drive one cycle of inputs, queue the expected post-edge outputs and
   // capture what the DUT shows 1 ns after the edge.
   task automatic step(input logic req, input logic eco, input logic tick,
                       input logic [7:0] win, input logic [3:0] door,
                       input logic [2:0] est, input logic eac, input logic eal,
                       input logic [7:0] ecnt);
      ac_request_i     = req;
      eco_mode_valid_i = eco;
      tick_i           = tick;
      WINDOW_STATUS_i  = win;
      DOOR_STATUS_i    = door;
      exp_q.push_back({est, eac, eal, ecnt});
      @(posedge clk_i);
      #1;
      obs_q.push_back({state_o, ac_enable_o, open_alarm_o, eco_off_count_o});
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      checks++;
      if ({state_o, ac_enable_o, open_alarm_o, eco_off_count_o} !== 13'd0) begin
         errors++;
         $display("FAIL reset: got st=%0d ac=%0b al=%0b cnt=%0d, expected all zero",
                  state_o, ac_enable_o, open_alarm_o, eco_off_count_o);
      end
      rst_ni = 1'b1;
   endtask

   // IDLE -> RUN -> WAIT_OFF (entry tick ignored) -> ECO_OFF after 3 ticks.
   task automatic test_eco_off();
      logic [12:0] e, o;
      int n = 0;
      step(1,1,0,8'h00,4'h0, 3'd0,0,0,8'd0);
      step(1,1,0,8'h00,4'h0, 3'd1,1,0,8'd0);
      step(1,1,0,8'h04,4'h0, 3'd1,1,0,8'd0);
      step(1,1,1,8'h04,4'h0, 3'd2,1,0,8'd0);
      step(1,1,1,8'h04,4'h0, 3'd2,1,0,8'd0);
      step(1,1,1,8'h04,4'h0, 3'd2,1,0,8'd0);
      step(1,1,0,8'h04,4'h0, 3'd2,1,0,8'd0);
      step(1,1,1,8'h04,4'h0, 3'd3,0,0,8'd1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n++; checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL eco_off step %0d: got st=%0d ac=%0b al=%0b cnt=%0d, expected st=%0d ac=%0b al=%0b cnt=%0d",
                     n, o[12:10], o[9], o[8], o[7:0], e[12:10], e[9], e[8], e[7:0]);
         end
      end
   endtask

   // ECO_OFF -> RESTART, reopen -> ECO_OFF again, then timed restart to RUN.
   task automatic test_restart();
      logic [12:0] e, o;
      int n = 0;
      step(1,1,0,8'h00,4'h0, 3'd3,0,0,8'd1);
      step(1,1,0,8'h00,4'h0, 3'd4,0,0,8'd1);
      step(1,1,1,8'h00,4'h0, 3'd4,0,0,8'd1);
      step(1,1,0,8'h00,4'h1, 3'd4,0,0,8'd1);
      step(1,1,0,8'h00,4'h1, 3'd3,0,0,8'd2);
      step(1,1,1,8'h00,4'h0, 3'd3,0,0,8'd2);
      step(1,1,0,8'h00,4'h0, 3'd4,0,0,8'd2);
      step(1,1,1,8'h00,4'h0, 3'd4,0,0,8'd2);
      step(1,1,1,8'h00,4'h0, 3'd1,1,0,8'd2);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n++; checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL restart step %0d: got st=%0d ac=%0b al=%0b cnt=%0d, expected st=%0d ac=%0b al=%0b cnt=%0d",
                     n, o[12:10], o[9], o[8], o[7:0], e[12:10], e[9], e[8], e[7:0]);
         end
      end
   endtask

   // Close the window after 2 ticks in WAIT_OFF: back to RUN, AC stays on.
   task automatic test_wait_abort();
      logic [12:0] e, o;
      int n = 0;
      step(1,1,0,8'h04,4'h0, 3'd1,1,0,8'd2);
      step(1,1,0,8'h04,4'h0, 3'd2,1,0,8'd2);
      step(1,1,1,8'h04,4'h0, 3'd2,1,0,8'd2);
      step(1,1,1,8'h00,4'h0, 3'd2,1,0,8'd2);
      step(1,1,0,8'h00,4'h0, 3'd1,1,0,8'd2);
      step(1,1,0,8'h00,4'h0, 3'd1,1,0,8'd2);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n++; checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL wait_abort step %0d: got st=%0d ac=%0b al=%0b cnt=%0d, expected st=%0d ac=%0b al=%0b cnt=%0d",
                     n, o[12:10], o[9], o[8], o[7:0], e[12:10], e[9], e[8], e[7:0]);
         end
      end
   endtask

   // Alarm on the 5th tick in ECO_OFF, saturates, clears on leaving ECO_OFF.
   task automatic test_alarm();
      logic [12:0] e, o;
      int n = 0;
      step(1,1,0,8'h04,4'h0, 3'd1,1,0,8'd2);
      step(1,1,0,8'h04,4'h0, 3'd2,1,0,8'd2);
      step(1,1,1,8'h04,4'h0, 3'd2,1,0,8'd2);
      step(1,1,1,8'h04,4'h0, 3'd2,1,0,8'd2);
      step(1,1,1,8'h04,4'h0, 3'd3,0,0,8'd3);
      for (int i = 1; i <= 4; i++) step(1,1,1,8'h04,4'h0, 3'd3,0,0,8'd3);
      step(1,1,1,8'h04,4'h0, 3'd3,0,1,8'd3);
      step(1,1,1,8'h04,4'h0, 3'd3,0,1,8'd3);
      step(1,0,0,8'h04,4'h0, 3'd3,0,1,8'd3);
      step(1,0,0,8'h04,4'h0, 3'd4,0,0,8'd3);
      step(1,1,0,8'h04,4'h0, 3'd4,0,0,8'd3);
      step(1,1,0,8'h04,4'h0, 3'd3,0,0,8'd4);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n++; checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL alarm step %0d: got st=%0d ac=%0b al=%0b cnt=%0d, expected st=%0d ac=%0b al=%0b cnt=%0d",
                     n, o[12:10], o[9], o[8], o[7:0], e[12:10], e[9], e[8], e[7:0]);
         end
      end
   endtask

   // Dropping the request in ECO_OFF, RUN, WAIT_OFF and RESTART.
   task automatic test_request_drop();
      logic [12:0] e, o;
      int n = 0;
      step(0,1,0,8'h04,4'h0, 3'd3,0,0,8'd4);
      step(0,1,0,8'h04,4'h0, 3'd0,0,0,8'd4);
      step(1,1,0,8'h00,4'h0, 3'd0,0,0,8'd4);
      step(1,1,0,8'h00,4'h0, 3'd1,1,0,8'd4);
      step(0,1,0,8'h00,4'h0, 3'd1,1,0,8'd4);
      step(0,1,0,8'h00,4'h0, 3'd0,0,0,8'd4);
      step(1,1,0,8'h00,4'h0, 3'd0,0,0,8'd4);
      step(1,1,0,8'h00,4'h0, 3'd1,1,0,8'd4);
      step(1,1,0,8'h04,4'h0, 3'd1,1,0,8'd4);
      step(1,1,0,8'h04,4'h0, 3'd2,1,0,8'd4);
      step(0,1,1,8'h04,4'h0, 3'd2,1,0,8'd4);
      step(0,1,1,8'h04,4'h0, 3'd0,0,0,8'd4);
      step(1,1,0,8'h04,4'h0, 3'd0,0,0,8'd4);
      step(1,1,0,8'h04,4'h0, 3'd3,0,0,8'd5);
      step(1,1,0,8'h00,4'h0, 3'd3,0,0,8'd5);
      step(1,1,0,8'h00,4'h0, 3'd4,0,0,8'd5);
      step(0,1,0,8'h00,4'h0, 3'd4,0,0,8'd5);
      step(0,1,0,8'h00,4'h0, 3'd0,0,0,8'd5);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n++; checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL request_drop step %0d: got st=%0d ac=%0b al=%0b cnt=%0d, expected st=%0d ac=%0b al=%0b cnt=%0d",
                     n, o[12:10], o[9], o[8], o[7:0], e[12:10], e[9], e[8], e[7:0]);
         end
      end
   endtask

   // Asynchronous reset in the middle of WAIT_OFF, then a fresh start.
   task automatic test_reset_mid();
      logic [12:0] e, o;
      int n = 0;
      step(1,1,0,8'h00,4'h0, 3'd0,0,0,8'd5);
      step(1,1,0,8'h00,4'h0, 3'd1,1,0,8'd5);
      step(1,1,0,8'h04,4'h0, 3'd1,1,0,8'd5);
      step(1,1,0,8'h04,4'h0, 3'd2,1,0,8'd5);
      step(1,1,1,8'h04,4'h0, 3'd2,1,0,8'd5);
      tick_i = 1'b0;
      #2 rst_ni = 1'b0;
      #1;
      checks++;
      if ({state_o, ac_enable_o, open_alarm_o, eco_off_count_o} !== 13'd0) begin
         errors++;
         $display("FAIL async_reset: got st=%0d ac=%0b al=%0b cnt=%0d, expected all zero",
                  state_o, ac_enable_o, open_alarm_o, eco_off_count_o);
      end
      @(posedge clk_i);
      #1 rst_ni = 1'b1;
      step(1,1,0,8'h04,4'h0, 3'd0,0,0,8'd0);
      step(1,1,0,8'h04,4'h0, 3'd3,0,0,8'd1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n++; checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL reset_mid step %0d: got st=%0d ac=%0b al=%0b cnt=%0d, expected st=%0d ac=%0b al=%0b cnt=%0d",
                     n, o[12:10], o[9], o[8], o[7:0], e[12:10], e[9], e[8], e[7:0]);
         end
      end
   endtask

   // Bounce between ECO_OFF and RESTART until the entry count saturates.
   task automatic test_saturate();
      logic [12:0] e, o;
      int n = 0;
      int model = 1;
      for (int i = 1; i <= 300; i++) begin
         if (i > 1 && model < 255) model++;
         step(1,1,0,8'h00,4'h0, 3'd3,0,0,8'(model));
         step(1,1,0,8'h04,4'h0, 3'd4,0,0,8'(model));
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n++; checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL saturate step %0d: got st=%0d ac=%0b al=%0b cnt=%0d, expected st=%0d ac=%0b al=%0b cnt=%0d",
                     n, o[12:10], o[9], o[8], o[7:0], e[12:10], e[9], e[8], e[7:0]);
         end
      end
      checks++;
      if (eco_off_count_o !== 8'd255) begin
         errors++;
         $display("FAIL saturate_final: got cnt=%0d, expected 255", eco_off_count_o);
      end
   endtask

   initial begin
      test_reset();
      test_eco_off();
      test_restart();
      test_wait_abort();
      test_alarm();
      test_request_drop();
      test_reset_mid();
      test_saturate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
